uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART byte transmitter (8N1, driven by `data_in`/`sbtn`, reporting `tx_busy`) between `NREQ` byte producers. It accepts one byte at a time from the winning requester over a valid/ready handshake and launches it with a single-cycle start pulse. It then tracks the transmitter's busy flag until the frame completes. It sits between the application-side byte sources and the transmitter, and is the only driver of the transmitter's `data_in` and `sbtn`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: maximum clk cycles allowed for `tx_busy` to rise after a start pulse.
- `clk` in 1: system clock, same clock as the transmitter.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: requester i has a byte pending.
- `req_data` in 8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_ready` out NREQ: one-hot accept; a byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_data` out 8: connects to transmitter `data_in`.
- `tx_start` out 1: connects to transmitter `sbtn`; single-cycle pulse.
- `tx_busy` in 1: transmitter busy flag.
- `grant_id` out $clog2(NREQ): index of the requester owning the current frame.
- `active` out 1: high from accept until the frame completes.
- `timeout_err` out 1: one-cycle pulse when `tx_busy` fails to rise.
- `frame_cnt` out 16: count of completed frames, wraps 0xFFFF→0.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - `req_ready` = one-hot round-robin winner among `req_valid`, only when `tx_busy`=0. It is combinational, and all zero in every other state.
  - On a transfer: latch `req_data` slice into `tx_data`, latch the index into `grant_id`, then go to LAUNCH.
- LAUNCH: `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - `tx_busy`=1 → go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `BUSY_TIMEOUT`, pulse `timeout_err`, go to IDLE, and leave `frame_cnt` unchanged.
- WAIT_DONE: `tx_busy`=0 → increment `frame_cnt` and go to IDLE.
- Round-robin pointer:
  - Search starts at `rr_ptr`, wrapping at NREQ-1→0.
  - After each accept, `rr_ptr` = granted index + 1 modulo NREQ.
  - Timeouts also advance the pointer.
- `tx_data` holds stable from accept until the next accept. `grant_id` holds its value between frames.
- `active` = (state != IDLE).
- A requester dropping `req_valid` after its accept has no effect on the frame in flight.
- `req_valid` rising mid-frame is served only after return to IDLE.
- Reset mid-frame: all state is cleared immediately. The transmitter is reset by the same `rst`.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0x00, `req_ready`=0, `grant_id`=0, `active`=0, `timeout_err`=0, `frame_cnt`=0.
  - `rr_ptr`=0, state IDLE.
- Accept at edge t: `tx_start`=1 during cycle t+1 and 0 from t+2 onward.
  - The transmitter's start state advances only on a baud tick with `sbtn` low, so `tx_start` must never be held high for 2 cycles.
- The transmitter raises `tx_busy` in cycle t+2, and the block enters WAIT_DONE at t+3.
- Frame end: the first cycle with `tx_busy`=0 in WAIT_DONE returns the block to IDLE on the next edge.
  - A new accept is possible in that IDLE cycle, giving a minimum gap of 1 idle cycle between frames.
- Back-to-back throughput is bounded by the transmitter: one byte per frame (10 baud ticks) plus 3 clk cycles.
- `timeout_err` asserts in the cycle after the counter reaches `BUSY_TIMEOUT`.

## Structure
- Shared package `uart_pkg`:
  - state enum `arb_state_t` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - constants `UART_DATA_W`=8 and `FRAME_CNT_W`=16.
- One sub-module, `rr_arbiter`:
  - parameter NREQ;
  - inputs `req`, `ptr`, `en`;
  - outputs one-hot `gnt` and `gnt_idx`;
  - purely combinational rotate / priority-pick / rotate-back.
- Top-level holds the FSM, the data/grant registers, the timeout counter and `frame_cnt`.

## Test plan
- Single requester: `req_valid`=0001, data 0xA5 → `req_ready[0]` for 1 cycle; `tx_start` high exactly 1 cycle, 1 cycle later; `tx_data`=0xA5; serial line shows 0,1,0,1,0,0,1,0,1,1 (LSB first); `frame_cnt`=1.
- Fairness: all 4 valid continuously with bytes 0x10..0x13 → grant order 0,1,2,3,0,…; after 8 frames `frame_cnt`=8 and each requester has 2 accepts.
- Pointer wrap: `rr_ptr`=3 after granting 2, only req 1 and 3 valid → req 3 granted, then req 1.
- Timeout: stub `tx_busy` tied 0 → `timeout_err` pulses 17 cycles after `tx_start`; state returns to IDLE; `frame_cnt` unchanged.
- Busy guard: force `tx_busy`=1 in IDLE with req valid → `req_ready` stays 0 until `tx_busy`=0.
- Reset mid-frame: assert `rst` in WAIT_DONE → all outputs at reset values the same cycle; after release, pending req 0 is served first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus transmitter-side signals of the shared UART arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    import uart_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [UART_DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]             req_ready;
    logic [UART_DATA_W-1:0]      tx_data;
    logic                        tx_start;
    logic                        tx_busy;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_data, tx_start
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_data, tx_start
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate requests so ptr is at bit 0,
// take the lowest set bit, rotate the index back.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]  rot;
    logic [IDX_W-1:0] rot_idx;
    logic             found;

    always_comb begin
        rot     = '0;
        rot_idx = '0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot[k] = req[(k + int'(ptr)) % NREQ];
        end
        // Descending scan so the lowest rotated position wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rot_idx = IDX_W'(k);
                found   = 1'b1;
            end
        end
        gnt_idx = IDX_W'((int'(rot_idx) + int'(ptr)) % NREQ);
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 8N1 UART transmitter among NREQ byte producers.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_arbiter_if.slave        bus,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active,
    output logic                    timeout_err,
    output logic [FRAME_CNT_W-1:0]  frame_cnt
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    arb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic [NREQ-1:0]        gnt;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   arb_en;
    logic                   accept;
    logic                   tmo_fire;
    logic                   frame_done;

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Gating on rst keeps req_ready low while reset is held, not just after it.
    assign arb_en = (state == IDLE) && !bus.tx_busy && !rst;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept        = |(gnt & bus.req_valid);
    assign bus.req_ready = gnt;
    assign bus.tx_data   = tx_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tmo_fire     = 1'b0;
        frame_done   = 1'b0;
        bus.tx_start = 1'b0;
        active       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                bus.tx_start = 1'b1;
                state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q   <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            timeout_err <= tmo_fire;
            if (accept) begin
                tx_data_q <= bus.req_data[gnt_idx*UART_DATA_W +: UART_DATA_W];
                grant_id  <= gnt_idx;
                rr_ptr    <= ptr_after(gnt_idx);
            end else if (tmo_fire) begin
                // A timed-out frame still consumes the owner's turn.
                rr_ptr <= ptr_after(grant_id);
            end
            if (state == LAUNCH) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_BUSY && !bus.tx_busy) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural 8N1 transmitter stub.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ         = 4;
    localparam int BUSY_TIMEOUT = 16;
    localparam int BAUD         = 4;
    localparam int LIMIT        = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    // Transmitter stub: busy the cycle after a start pulse, 10 bits of BAUD clocks each
    logic       m_busy;
    logic [9:0] m_sh;
    int         m_bit;
    int         m_div;
    logic       force0 = 1'b0;
    logic       force1 = 1'b0;
    bit         line_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_sh   <= '1;
            m_bit  <= 0;
            m_div  <= 0;
        end else if (!m_busy) begin
            if (bus.tx_start) begin
                m_busy <= 1'b1;
                m_sh   <= {1'b1, bus.tx_data, 1'b0};
                m_bit  <= 0;
                m_div  <= 0;
            end
        end else if (m_div == BAUD - 1) begin
            m_div <= 0;
            line_q.push_back(m_sh[m_bit]);
            if (m_bit == 9) m_busy <= 1'b0;
            m_bit <= m_bit + 1;
        end else begin
            m_div <= m_div + 1;
        end
    end

    assign bus.tx_busy = force1 ? 1'b1 : (force0 ? 1'b0 : m_busy);

    int total = 0;
    int bad   = 0;
    int fc_exp = 0;
    int ptr_m  = 0;

    typedef struct {
        bit         rst_first;
        logic [3:0] mask;
        int         exp_gnt;
    } vec_t;

    vec_t        tbl[11];
    int          acc[NREQ];
    int          idx;
    int          hit;
    int          exp_i;
    logic [3:0]  mask;
    logic [31:0] data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        force0        = 1'b0;
        force1        = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        fc_exp = 0;
        ptr_m  = 0;
    endtask

    task automatic wait_accept(output int got);
        got = -1;
        for (int c = 0; c < LIMIT; c++) begin
            #1;
            if (|(bus.req_valid & bus.req_ready)) begin
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) got = i;
                return;
            end
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL accept_wait got=none exp=accept within %0d cycles", LIMIT);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            #1;
            if (!active) return;
        end
        total++;
        bad++;
        $display("FAIL idle_wait got=active exp=idle within %0d cycles", LIMIT);
    endtask

    task automatic run_frame(input int exp_idx, input logic [7:0] exp_byte,
                             input logic [3:0] after_mask, input bit scramble,
                             output int got_idx);
        int         base;
        logic [9:0] bits;
        wait_accept(got_idx);
        chk("grant_idx", got_idx, exp_idx);
        chk("req_ready_onehot", {28'd0, bus.req_ready}, 32'd1 << exp_idx);
        @(negedge clk);
        bus.req_valid = after_mask;
        if (scramble) bus.req_data = $urandom;
        base = line_q.size();
        #1;
        chk("tx_start_pulse", bus.tx_start, 1);
        chk("tx_data", bus.tx_data, exp_byte);
        chk("grant_id", grant_id, exp_idx);
        chk("active", active, 1);
        chk("req_ready_busy", bus.req_ready, 0);
        @(negedge clk);
        #1;
        chk("tx_start_off", bus.tx_start, 0);
        wait_idle();
        fc_exp++;
        chk("frame_cnt", frame_cnt, fc_exp & 32'hFFFF);
        chk("tx_data_hold", bus.tx_data, exp_byte);
        chk("line_len", line_q.size() - base, 10);
        if (line_q.size() - base == 10) begin
            for (int k = 0; k < 10; k++) bits[k] = line_q[base + k];
            chk("line_bits", bits, {1'b1, exp_byte, 1'b0});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'b1111, 0};
        tbl[1]  = '{1'b0, 4'b1111, 1};
        tbl[2]  = '{1'b0, 4'b1111, 2};
        tbl[3]  = '{1'b0, 4'b1111, 3};
        tbl[4]  = '{1'b0, 4'b1111, 0};
        tbl[5]  = '{1'b0, 4'b1111, 1};
        tbl[6]  = '{1'b0, 4'b1111, 2};
        tbl[7]  = '{1'b0, 4'b1111, 3};
        tbl[8]  = '{1'b1, 4'b0100, 2};
        tbl[9]  = '{1'b0, 4'b1010, 3};
        tbl[10] = '{1'b0, 4'b1010, 1};
        for (int i = 0; i < NREQ; i++) acc[i] = 0;

        // Reset state, with a request already pending
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h000000A5;
        @(negedge clk);
        #1;
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_active", active, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // Single requester, 0xA5
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h000000A5;
        run_frame(0, 8'hA5, 4'b0000, 1'b0, idx);

        // Fairness and pointer wrap from the vector table
        for (int v = 0; v < 11; v++) begin
            if (tbl[v].rst_first) do_reset();
            bus.req_data  = 32'h13121110;
            bus.req_valid = tbl[v].mask;
            run_frame(tbl[v].exp_gnt, 8'(16 + tbl[v].exp_gnt), tbl[v].mask, 1'b0, idx);
            if (v < 8 && idx >= 0) acc[idx]++;
            if (v == 7) begin
                for (int i = 0; i < NREQ; i++) chk("fair_accepts", acc[i], 2);
            end
        end

        // Randomised traffic against a first-valid-from-pointer model
        do_reset();
        for (int n = 0; n < 30; n++) begin
            mask = 4'($urandom_range(1, 15));
            data = $urandom;
            exp_i = -1;
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (mask[(ptr_m + k) % NREQ]) exp_i = (ptr_m + k) % NREQ;
            end
            bus.req_valid = mask;
            bus.req_data  = data;
            run_frame(exp_i, data[8*exp_i +: 8], 4'b0000, 1'b1, idx);
            ptr_m = (exp_i + 1) % NREQ;
        end

        // Busy guard
        do_reset();
        force1        = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000005C;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("busy_guard_ready", bus.req_ready, 0);
        end
        force1 = 1'b0;
        #1;
        chk("busy_release_ready", bus.req_ready, 4'b0001);
        run_frame(0, 8'h5C, 4'b0000, 1'b0, idx);

        // Timeout with busy stuck low
        do_reset();
        force0        = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h00000077;
        wait_accept(idx);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        chk("tmo_tx_start", bus.tx_start, 1);
        hit = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (timeout_err) begin
                hit = k;
                break;
            end
        end
        chk("tmo_cycle", hit, 17);
        chk("tmo_active", active, 0);
        chk("tmo_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        #1;
        chk("tmo_pulse_width", timeout_err, 0);

        // Reset in WAIT_DONE; afterwards req 0 must win over req 1
        do_reset();
        bus.req_data  = 32'h44332211;
        bus.req_valid = 4'b0100;
        run_frame(2, 8'h33, 4'b0000, 1'b0, idx);
        bus.req_valid = 4'b0001;
        wait_accept(idx);
        chk("midrst_grant", idx, 0);
        @(negedge clk);
        bus.req_valid = 4'b0011;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst_active", active, 1);
        chk("midrst_busy", bus.tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_tx_start", bus.tx_start, 0);
        chk("midrst_tx_data", bus.tx_data, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_active_clr", active, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        rst    = 1'b0;
        fc_exp = 0;
        run_frame(0, 8'h11, 4'b0000, 1'b0, idx);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
